// File: rtl/alu_mult_sequencer.sv
// Shift-add 32x32 -> low-32 multiplier sequencing the shared ALU (add for accumulate, sll for multiplicand).
// Latency (k+1)+p+1 cycles from accepted start to done; start ignored while busy, abort cancels ADD/SHIFT.
module alu_mult_sequencer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] alu_opA,
  output logic [31:0] alu_opB,
  output logic [4:0]  alu_opcode,
  output logic [4:0]  alu_shiftamt,
  input  logic [31:0] alu_result
);

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SLL = 5'b00100;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ADD    = 2'd1,
    S_SHIFT  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] result_q, result_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    acc_d        = acc_q;
    result_d     = result_q;
    busy         = 1'b0;
    done         = 1'b0;
    alu_opA      = '0;
    alu_opB      = '0;
    alu_opcode   = OP_ADD;
    alu_shiftamt = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          mcand_d  = operand_a;
          mplier_d = operand_b;
          acc_d    = '0;
          state_d  = operand_b[0] ? S_ADD : S_SHIFT;
        end
      end

      S_ADD: begin
        busy    = 1'b1;
        alu_opA = acc_q;
        alu_opB = mcand_q;
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          acc_d   = alu_result;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        busy         = 1'b1;
        alu_opcode   = OP_SLL;
        alu_opA      = mcand_q;
        alu_shiftamt = 5'd1;
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          mcand_d  = alu_result;
          mplier_d = {1'b0, mplier_q[31:1]};
          // acc is already final here: an ADD always precedes the last SHIFT of a set bit
          if (mplier_q[31:1] == 31'd0) begin
            result_d = acc_q;
            state_d  = S_FINISH;
          end else begin
            state_d = mplier_q[1] ? S_ADD : S_SHIFT;
          end
        end
      end

      S_FINISH: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign result = result_q;

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Directed bench for alu_mult_sequencer with a behavioural add/sll ALU beside it.
module tb_alu_mult_sequencer;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] alu_opA;
  logic [31:0] alu_opB;
  logic [4:0]  alu_opcode;
  logic [4:0]  alu_shiftamt;
  logic [31:0] alu_result;

  int n_vec;
  int n_err;

  alu_mult_sequencer dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .alu_opA      (alu_opA),
    .alu_opB      (alu_opB),
    .alu_opcode   (alu_opcode),
    .alu_shiftamt (alu_shiftamt),
    .alu_result   (alu_result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // External ALU: add and sll only; any other opcode reads as zero.
  always_comb begin
    alu_result = 32'h0;
    if (alu_opcode == 5'b00000)      alu_result = alu_opA + alu_opB;
    else if (alu_opcode == 5'b00100) alu_result = alu_opA << alu_shiftamt;
  end

  // Called at #1 inside an IDLE cycle; returns at #1 inside the done cycle (or on timeout).
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_cyc, input string name);
    int cyc;
    start = 1'b1; operand_a = a; operand_b = b;
    @(posedge clock); #1;
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 80) begin
      @(posedge clock); #1;
      cyc++;
    end
    n_vec++;
    if (cyc !== exp_cyc) begin
      n_err++;
      $display("FAIL %s_latency got %0d want %0d", name, cyc, exp_cyc);
    end
    n_vec++;
    if (result !== exp_res) begin
      n_err++;
      $display("FAIL %s_result got %h want %h", name, result, exp_res);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; operand_a = '0; operand_b = '0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;
    n_vec++;
    if ({busy, done, result, alu_opcode, alu_shiftamt, alu_opA, alu_opB} !== {2'b00, 32'h0, 5'd0, 5'd0, 64'h0}) begin
      n_err++;
      $display("FAIL reset got busy=%b done=%b res=%h op=%b sa=%0d", busy, done, result, alu_opcode, alu_shiftamt);
    end
  endtask

  task automatic test_basic();
    // Expected {busy,done,opcode,shiftamt} for ADD,SHIFT,SHIFT,ADD,SHIFT,FINISH
    logic [11:0] exp_seq [6];
    exp_seq[0] = {2'b10, 5'b00000, 5'd0};
    exp_seq[1] = {2'b10, 5'b00100, 5'd1};
    exp_seq[2] = {2'b10, 5'b00100, 5'd1};
    exp_seq[3] = {2'b10, 5'b00000, 5'd0};
    exp_seq[4] = {2'b10, 5'b00100, 5'd1};
    exp_seq[5] = {2'b11, 5'b00000, 5'd0};
    start = 1'b1; operand_a = 32'd3; operand_b = 32'd5;
    @(posedge clock); #1;
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if ({busy, done, alu_opcode, alu_shiftamt} !== exp_seq[i]) begin
        n_err++;
        $display("FAIL basic_cycle%0d got %b want %b", i + 1, {busy, done, alu_opcode, alu_shiftamt}, exp_seq[i]);
      end
      if (i < 5) begin
        @(posedge clock); #1;
      end
    end
    n_vec++;
    if (result !== 32'd15) begin
      n_err++;
      $display("FAIL basic_result got %h want %h", result, 32'd15);
    end
    @(posedge clock); #1;
    n_vec++;
    if ({busy, done} !== 2'b00) begin
      n_err++;
      $display("FAIL basic_idle got %b want 00", {busy, done});
    end
  endtask

  task automatic test_zero_and_finish_start();
    run_mult(32'h1234, 32'h0, 32'h0, 2, "zero");
    // Now in FINISH: a start here must be dropped
    start = 1'b1; operand_a = 32'd5; operand_b = 32'd5;
    @(posedge clock); #1;
    start = 1'b0;
    n_vec++;
    if ({busy, done} !== 2'b00) begin
      n_err++;
      $display("FAIL finish_start got %b want 00", {busy, done});
    end
  endtask

  task automatic test_wrap();
    run_mult(32'h00010000, 32'h00010000, 32'h0, 19, "wrap16");
    @(posedge clock); #1;
    run_mult(32'hFFFFFFFE, 32'd7, 32'hFFFFFFF2, 7, "signed");
    @(posedge clock); #1;
  endtask

  task automatic test_abort();
    int dones;
    start = 1'b1; abort = 1'b1; operand_a = 32'd2; operand_b = 32'd2;
    @(posedge clock); #1;
    start = 1'b0; abort = 1'b0;
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_abort_blocks got busy=%b want 0", busy);
    end
    start = 1'b1; operand_a = 32'd9; operand_b = 32'h80000000;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1 abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    n_vec++;
    if ({busy, done, result} !== {2'b00, 32'hFFFFFFF2}) begin
      n_err++;
      $display("FAIL abort got busy=%b done=%b res=%h want 0 0 fffffff2", busy, done, result);
    end
    dones = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done === 1'b1) dones++;
    end
    n_vec++;
    if (dones !== 0 || result !== 32'hFFFFFFF2) begin
      n_err++;
      $display("FAIL abort_quiet got dones=%0d res=%h want 0 fffffff2", dones, result);
    end
  endtask

  task automatic test_back_to_back();
    run_mult(32'd6, 32'd7, 32'd42, 7, "after_abort");
    @(posedge clock); #1;
    run_mult(32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 65, "max");
    @(posedge clock); #1;
  endtask

  task automatic test_async_reset();
    start = 1'b1; operand_a = 32'd1; operand_b = 32'hFFFFFFFF;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (19) @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, done, result, alu_opcode} !== {2'b00, 32'h0, 5'd0}) begin
      n_err++;
      $display("FAIL async_reset got busy=%b done=%b res=%h op=%b", busy, done, result, alu_opcode);
    end
    #1 reset_n = 1'b1;
    @(posedge clock); #1;
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_idle got busy=%b want 0", busy);
    end
    run_mult(32'd3, 32'd5, 32'd15, 6, "post_reset");
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_zero_and_finish_start();
    test_wrap();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_mult_sequencer.md
# alu_mult_sequencer

Multi-cycle 32-bit multiplier controller that computes the low 32 bits of A×B by driving the shared combinational ALU through a shift-add sequence: ALU add for accumulation, ALU sll for multiplicand shifting. It sits beside the ALU in the execute stage and owns the ALU's operand/opcode/shiftamt inputs while busy. The pipeline's hazard logic stalls on `busy` and takes the product on `done`.

## Interface
- No parameters; all widths are fixed at 32-bit data and 5-bit opcode/shift.
- clock  in  1  single clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- abort  in  1  cancel an in-flight multiply.
- operand_a  in  32  multiplicand, captured on accepted start.
- operand_b  in  32  multiplier, captured on accepted start.
- busy  out  1  high in ADD, SHIFT and FINISH.
- done  out  1  one-cycle pulse in FINISH.
- result  out  32  registered product, held until the next completion.
- alu_opA  out  32  to ALU data_operandA.
- alu_opB  out  32  to ALU data_operandB.
- alu_opcode  out  5  to ALU ctrl_ALUopcode.
- alu_shiftamt  out  5  to ALU ctrl_shiftamt.
- alu_result  in  32  from ALU data_result; combinational, valid in the same cycle.

## Operation
- Internal registers:
  - mcand[31:0]: running multiplicand.
  - mplier[31:0]: remaining multiplier bits.
  - acc[31:0]: partial product.
  - state: one of IDLE, ADD, SHIFT, FINISH.
- IDLE:
  - ALU drive: opcode 00000, opA 0, opB 0, shiftamt 0.
  - start=1 and abort=0 → mcand←operand_a, mplier←operand_b, acc←0.
  - Next state is ADD if operand_b[0]=1, else SHIFT.
- ADD:
  - ALU drive: opcode 00000, opA=acc, opB=mcand, shiftamt 0.
  - acc←alu_result; next state SHIFT.
- SHIFT:
  - ALU drive: opcode 00100, opA=mcand, opB 0, shiftamt 00001.
  - mcand←alu_result; mplier←mplier>>1 (logical, internal, not via the ALU).
  - If (mplier>>1)==0 → FINISH and result←acc.
  - Otherwise → ADD if mplier[1]=1, else SHIFT.
- FINISH:
  - done=1 and busy=1 for exactly one cycle, then IDLE.
  - ALU drive is the same as IDLE.
- Arithmetic:
  - All adds are modulo 2^32; bits shifted out of mcand and the ALU carry-out are discarded.
  - The result is the low word of the product, correct for both signed and unsigned two's-complement operands.
  - No overflow flag.
- start while not IDLE, including FINISH: ignored, no queuing.
- abort:
  - In ADD or SHIFT → IDLE on the next edge; no done, result unchanged.
  - abort in FINISH: ignored; done still pulses.
  - abort in IDLE: no effect, and it blocks a same-cycle start.
- ALU opcode outputs are always one of 00000 or 00100, so the ALU never drives a floating (all-buffers-off) result.

## Timing
- Reset (asynchronous assert; release synchronous to clock): state IDLE; mcand, mplier, acc, result=0; busy=0; done=0; ALU outputs as IDLE.
- Latency:
  - Let k be the highest set bit of operand_b, and p the popcount of operand_b[k:0].
  - Cycles from the accepting edge to the done cycle = (k+1) + p + 1.
  - operand_b=0 is treated as k=0: SHIFT then FINISH, done in cycle 2.
  - Maximum is 65 cycles (operand_b=0xFFFFFFFF).
- result updates on the edge entering FINISH and is valid in the done cycle and thereafter.
- Back-to-back: the earliest next start is sampled in the first IDLE cycle after FINISH.
- Reset asserted mid-operation: immediate IDLE; result is cleared to 0.

## Test plan
- Reset then idle: reset_n low for 2 cycles, then release → busy=0, done=0, result=0, alu_opcode=00000.
- Basic multiply: start with A=3, B=5 → state sequence ADD, SHIFT, SHIFT, ADD, SHIFT, FINISH; done in cycle 6; result=15. Check alu_opcode=00100 with shiftamt=1 in SHIFT cycles.
- Signed and wrap cases:
  - A=0xFFFFFFFE, B=7 → result=0xFFFFFFF2.
  - A=0x00010000, B=0x00010000 → result=0.
  - A=1, B=0xFFFFFFFF → done at cycle 65, result=0xFFFFFFFF.
- Zero multiplier: A=0x1234, B=0 → done in cycle 2, result=0. Then start during FINISH → ignored, busy drops next cycle.
- Abort:
  - A=9, B=0x80000000, abort in cycle 10 → IDLE next cycle, no done, result keeps its prior value.
  - A new start (A=6, B=7) → result=42.
- Async reset mid-run: reset_n pulsed low between clock edges in cycle 20 of a 65-cycle multiply → busy=0 and result=0 immediately, without waiting for a clock edge.
